// File: rtl/mem_isa_pkg.sv
// Shared ISA definitions for the memory issue path.
// Contents:
//   opcode_t       : 4-bit opcodes carried in instr[31:28]
//   sched_state_t  : issue scheduler FSM states
//   get_opcode / get_reg / get_imm : instruction field slices
//   is_line_op     : true for opcodes that occupy a BRAM line slot
package mem_isa_pkg;

  localparam int unsigned ISA_INSTR_W = 32;

  typedef enum logic [3:0] {
    OP_NOP        = 4'b0000,
    OP_SET_ADDR   = 4'b0111,
    OP_WRITE_IMM  = 4'b1110,
    OP_READ_LINE  = 4'b1100,
    OP_WRITE_LINE = 4'b1010,
    OP_LOAD_ABC   = 4'b1101
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_STALL_BRAM = 2'd2,
    ST_STALL_WB   = 2'd3
  } sched_state_t;

  function automatic logic [3:0] get_opcode(input logic [ISA_INSTR_W-1:0] instr);
    return instr[31:28];
  endfunction

  function automatic logic [3:0] get_reg(input logic [ISA_INSTR_W-1:0] instr);
    return instr[27:24];
  endfunction

  function automatic logic [23:0] get_imm(input logic [ISA_INSTR_W-1:0] instr);
    return instr[23:0];
  endfunction

  function automatic logic is_line_op(input logic [3:0] op);
    return (op == OP_READ_LINE) || (op == OP_WRITE_LINE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered occupancy count.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push      : write wr_data (ignored when full)
//   pop       : discard head (ignored when empty)
//   wr_data   : data in
//   rd_data   : current head (valid when !empty)
//   count     : registered occupancy, 0..DEPTH
//   full/empty: decoded from the registered count
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Pointer and occupancy bookkeeping; power-of-two depth makes pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only observed behind a valid count, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/memory_issue_sched.sv
// In-order issue scheduler between the controller instruction stream and memory.
// Queues instructions, drops NOPs, spaces BRAM line ops and waits for a full write
// buffer before WRITE_LINE, forwarding one instruction per cycle.
// Ports:
//   clk_in, rst_in          : clock, synchronous active-high reset
//   instr_in/_valid_in      : controller instruction stream
//   instr_ready_out         : FIFO not full (from registered count)
//   write_buffer_valid_in   : write buffer holds a complete line
//   mem_instr_out/_valid_out: registered issued instruction + one-cycle valid
//   write_buffer_pop_out    : pulses alongside an issued WRITE_LINE
//   busy_out                : queue non-empty or line-op spacing still running
//   stall_cycles_out        : saturating count of cycles a real head was held
module memory_issue_sched
  import mem_isa_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned BRAM_LATENCY      = 2,
  parameter int unsigned STALL_CNT_WIDTH   = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
  input  logic                         instr_valid_in,
  output logic                         instr_ready_out,
  input  logic                         write_buffer_valid_in,
  output logic [INSTRUCTION_WIDTH-1:0] mem_instr_out,
  output logic                         mem_instr_valid_out,
  output logic                         write_buffer_pop_out,
  output logic                         busy_out,
  output logic [STALL_CNT_WIDTH-1:0]   stall_cycles_out
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SCW = $clog2(BRAM_LATENCY + 1);

  logic [INSTRUCTION_WIDTH-1:0] head_s;
  logic [CW-1:0]                fifo_count_s;
  logic                         fifo_full_s;
  logic                         fifo_empty_s;
  logic                         push_s;
  logic                         pop_s;
  logic                         issue_s;
  logic                         held_s;
  logic                         spacing_ok_s;
  logic [3:0]                   head_op_s;
  sched_state_t                 state_r;
  sched_state_t                 state_next_s;
  logic [SCW-1:0]               spc_cnt_r;
  logic [INSTRUCTION_WIDTH-1:0] mem_instr_r;
  logic                         mem_valid_r;
  logic                         wb_pop_r;
  logic [STALL_CNT_WIDTH-1:0]   stall_r;

  assign instr_ready_out = ~fifo_full_s;
  assign push_s          = instr_valid_in & instr_ready_out;
  assign head_op_s       = get_opcode(head_s);
  // The counter is reloaded with BRAM_LATENCY and the next line op is allowed once it
  // reaches 1 (it hits 0 at that same edge), so successive line ops are BRAM_LATENCY
  // cycles apart.
  assign spacing_ok_s    = (spc_cnt_r <= SCW'(1'b1));

  sync_fifo #(
    .WIDTH (INSTRUCTION_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_in),
    .rst     (rst_in),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (instr_in),
    .rd_data (head_s),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Hazard check on the FIFO head: decide issue, pop and hold for this cycle.
  always_comb begin
    issue_s = 1'b0;
    pop_s   = 1'b0;
    held_s  = 1'b0;
    if (fifo_empty_s) begin
      issue_s = 1'b0;
      pop_s   = 1'b0;
      held_s  = 1'b0;
    end else begin
      case (head_op_s)
        OP_NOP:        issue_s = 1'b0;
        OP_READ_LINE:  issue_s = spacing_ok_s;
        OP_WRITE_LINE: issue_s = spacing_ok_s & write_buffer_valid_in;
        default:       issue_s = 1'b1;
      endcase
      pop_s  = issue_s | (head_op_s == OP_NOP);
      held_s = ~pop_s;
    end
  end

  // Next-state logic; a held head names the hazard that is blocking it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (push_s) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE, ST_STALL_BRAM, ST_STALL_WB: begin
        if (held_s) begin
          if (is_line_op(head_op_s) && !spacing_ok_s) begin
            state_next_s = ST_STALL_BRAM;
          end else begin
            state_next_s = ST_STALL_WB;
          end
        end else if (!push_s && (fifo_empty_s || (pop_s && (fifo_count_s == CW'(1'b1))))) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Line-op spacing counter: reload on a line-op issue, otherwise count down to zero.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      spc_cnt_r <= {SCW{1'b0}};
    end else if (issue_s && is_line_op(head_op_s)) begin
      spc_cnt_r <= SCW'(BRAM_LATENCY);
    end else if (spc_cnt_r != {SCW{1'b0}}) begin
      spc_cnt_r <= spc_cnt_r - SCW'(1'b1);
    end else begin
      spc_cnt_r <= spc_cnt_r;
    end
  end

  // Registered issue outputs; the instruction bus keeps its last issued value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_instr_r <= {INSTRUCTION_WIDTH{1'b0}};
      mem_valid_r <= 1'b0;
      wb_pop_r    <= 1'b0;
    end else begin
      mem_valid_r <= issue_s;
      wb_pop_r    <= issue_s & (head_op_s == OP_WRITE_LINE);
      if (issue_s) begin
        mem_instr_r <= head_s;
      end else begin
        mem_instr_r <= mem_instr_r;
      end
    end
  end

  // Saturating stall counter; NOP pops are never counted as stalls.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_r <= {STALL_CNT_WIDTH{1'b0}};
    end else if (held_s && (stall_r != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_r <= stall_r + STALL_CNT_WIDTH'(1'b1);
    end else begin
      stall_r <= stall_r;
    end
  end

  assign mem_instr_out        = mem_instr_r;
  assign mem_instr_valid_out  = mem_valid_r;
  assign write_buffer_pop_out = wb_pop_r;
  assign busy_out             = ~fifo_empty_s | (spc_cnt_r != {SCW{1'b0}});
  assign stall_cycles_out     = stall_r;

endmodule
